// File: rtl/usbdev_pkg.sv
// Shared types and line-state constants for the usbdev transmit path.
package usbdev_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    DATA    = 3'd2,
    STUFF   = 3'd3,
    EOP_SE0 = 3'd4,
    EOP_J   = 3'd5
  } tx_state_e;

  // Line states as {dp, dm}
  localparam logic [1:0] LS_SE0  = 2'b00;
  localparam logic [1:0] LS_J_FS = 2'b10;
  localparam logic [1:0] LS_K_FS = 2'b01;
  localparam logic [1:0] LS_J_LS = 2'b01;
  localparam logic [1:0] LS_K_LS = 2'b10;

  // A run of this many raw ones forces a stuffed zero.
  localparam int unsigned STUFF_LIMIT = 6;

  function automatic logic [1:0] j_pair(input bit low_speed);
    return low_speed ? LS_J_LS : LS_J_FS;
  endfunction

  function automatic logic [1:0] k_pair(input bit low_speed);
    return low_speed ? LS_K_LS : LS_K_FS;
  endfunction

endpackage

// File: rtl/usb_nrzi_stuffer.sv
// NRZI encoder plus ones-run counter. Holds the current J/K line level and
// raises stuff_req once STUFF_LIMIT consecutive ones have been emitted.
// tick is asserted only on bit boundaries where a J/K bit is put on the line.
module usb_nrzi_stuffer
  import usbdev_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic tick,
  input  logic raw_bit,
  output logic nrzi_j,
  output logic stuff_req
);

  localparam int unsigned CNT_W = $clog2(STUFF_LIMIT + 1);

  logic [CNT_W-1:0] ones_q;

  // Line level and ones-run counter; start encodes the first bit relative to J.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nrzi_j <= 1'b1;
      ones_q <= '0;
    end else if (start) begin
      nrzi_j <= raw_bit;
      ones_q <= {{(CNT_W-1){1'b0}}, raw_bit};
    end else if (tick) begin
      if (raw_bit) begin
        ones_q <= ones_q + 1'b1;
      end else begin
        nrzi_j <= ~nrzi_j;
        ones_q <= '0;
      end
    end
  end

  assign stuff_req = (ones_q == CNT_W'(STUFF_LIMIT));

endmodule

// File: rtl/usb_line_tx.sv
// Full/low-speed USB line transmitter: SYNC, bit-stuffed NRZI data, EOP.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | line parked at J, pads released; waits for ena && tx_valid
// SYNC    | SYNC_BITS-1 zeros then a one, NRZI encoded
// DATA    | 8 bits of byte_q LSB first; byte handshake at end of bit 7
// STUFF   | one stuffed zero; bit index frozen, eop_pend_q picks the exit
// EOP_SE0 | SE0 for EOP_SE0_BITS bit periods
// EOP_J   | J for one bit period, then release pads
module usb_line_tx
  import usbdev_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          LOW_SPEED    = 1'b0,
  parameter int unsigned SYNC_BITS    = 8,
  parameter int unsigned EOP_SE0_BITS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       dp_out,
  output logic       dm_out,
  output logic       oe,
  output logic       busy,
  output logic       underrun
);

  localparam int unsigned TMR_W   = $clog2(CLKS_PER_BIT);
  localparam int unsigned CNT_MAX = (SYNC_BITS > EOP_SE0_BITS) ?
                                    ((SYNC_BITS > 8) ? SYNC_BITS : 8) :
                                    ((EOP_SE0_BITS > 8) ? EOP_SE0_BITS : 8);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_BITS - 1);
  localparam logic [CNT_W-1:0] EOP_LAST  = CNT_W'(EOP_SE0_BITS - 1);

  tx_state_e        state_q, state_d;
  logic [TMR_W-1:0] tmr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]       idx_inc;
  logic [7:0]       byte_q, byte_d;
  logic             last_q, last_d;
  logic             eop_pend_q, eop_pend_d;
  logic             underrun_q, underrun_d;
  logic             ready_en_q;
  logic             tick;
  logic             pkt_end;
  logic             stf_start, stf_tick, stf_bit;
  logic             nrzi_j, stuff_req;

  // cnt_q is the SYNC bit index, the DATA bit index or the SE0 bit index.
  assign tick    = (state_q != IDLE) && (tmr_q == TMR_LAST);
  assign cnt_inc = cnt_q + 1'b1;
  assign idx_inc = cnt_q[2:0] + 3'd1;

  usb_nrzi_stuffer u_nrzi_stuffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (stf_start),
    .tick      (stf_tick),
    .raw_bit   (stf_bit),
    .nrzi_j    (nrzi_j),
    .stuff_req (stuff_req)
  );

  // State register and per-packet context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      byte_q     <= '0;
      last_q     <= 1'b0;
      eop_pend_q <= 1'b0;
      underrun_q <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      last_q     <= last_d;
      eop_pend_q <= eop_pend_d;
      underrun_q <= underrun_d;
      ready_en_q <= 1'b1;
    end
  end

  // Bit timer: restarts on packet start and on every bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= '0;
    end else if (state_q == IDLE || tick) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_q + 1'b1;
    end
  end

  // Next-state, byte handshake and raw-bit selection for the NRZI stage.
  // ready_en_q keeps tx_ready low until the first edge after reset.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_d     = byte_q;
    last_d     = last_q;
    eop_pend_d = eop_pend_q;
    underrun_d = 1'b0;
    tx_ready   = 1'b0;
    pkt_end    = 1'b0;
    stf_start  = 1'b0;
    stf_tick   = 1'b0;
    stf_bit    = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_ready = ena && ready_en_q;
        if (ena && ready_en_q && tx_valid) begin
          state_d    = SYNC;
          cnt_d      = '0;
          byte_d     = tx_data;
          last_d     = tx_last;
          eop_pend_d = 1'b0;
          stf_start  = 1'b1;
          stf_bit    = (SYNC_BITS == 1);
        end
      end
      SYNC: begin
        if (tick) begin
          stf_tick = 1'b1;
          if (cnt_q == SYNC_LAST) begin
            state_d = DATA;
            cnt_d   = '0;
            stf_bit = byte_q[0];
          end else begin
            cnt_d   = cnt_inc;
            stf_bit = (cnt_inc == SYNC_LAST);
          end
        end
      end
      DATA: begin
        if (tick) begin
          stf_tick = 1'b1;
          if (cnt_q[2:0] == 3'd7) begin
            if (last_q) begin
              pkt_end = 1'b1;
            end else begin
              tx_ready = 1'b1;
              if (tx_valid) begin
                byte_d = tx_data;
                last_d = tx_last;
              end else begin
                underrun_d = 1'b1;
                pkt_end    = 1'b1;
              end
            end
            eop_pend_d = pkt_end;
            if (stuff_req) begin
              state_d = STUFF;
            end else if (pkt_end) begin
              state_d  = EOP_SE0;
              cnt_d    = '0;
              stf_tick = 1'b0;
            end else begin
              cnt_d   = '0;
              stf_bit = tx_data[0];
            end
          end else if (stuff_req) begin
            state_d = STUFF;
          end else begin
            cnt_d   = CNT_W'(idx_inc);
            stf_bit = byte_q[idx_inc];
          end
        end
      end
      STUFF: begin
        if (tick) begin
          if (eop_pend_q) begin
            state_d = EOP_SE0;
            cnt_d   = '0;
          end else begin
            state_d  = DATA;
            cnt_d    = CNT_W'(idx_inc);
            stf_tick = 1'b1;
            stf_bit  = byte_q[idx_inc];
          end
        end
      end
      EOP_SE0: begin
        if (tick) begin
          if (cnt_q == EOP_LAST) begin
            state_d = EOP_J;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      EOP_J: begin
        if (tick) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Line decode from registered state and NRZI level.
  always_comb begin
    {dp_out, dm_out} = j_pair(LOW_SPEED);
    unique case (state_q)
      SYNC, DATA, STUFF: {dp_out, dm_out} = nrzi_j ? j_pair(LOW_SPEED) : k_pair(LOW_SPEED);
      EOP_SE0:           {dp_out, dm_out} = LS_SE0;
      default:           {dp_out, dm_out} = j_pair(LOW_SPEED);
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign oe       = busy;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_usb_line_tx.sv
// Bench for usb_line_tx: an FS and an LS instance share stimulus; every
// clock of each packet is compared against a bit-list model of the frame.
`timescale 1ns/1ps
module tb_usb_line_tx;

  localparam int CPB    = 4;
  localparam int SYNC_N = 8;
  localparam int EOP_N  = 2;

  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  typedef logic [11:0] obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       rdy_fs, dp_fs, dm_fs, oe_fs, busy_fs, und_fs;
  logic       rdy_ls, dp_ls, dm_ls, oe_ls, busy_ls, und_ls;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] pkt[$];
  obs_t       exp_q[$];

  always #5 clk = ~clk;

  usb_line_tx #(.CLKS_PER_BIT(CPB), .LOW_SPEED(1'b0), .SYNC_BITS(SYNC_N), .EOP_SE0_BITS(EOP_N)) dut_fs (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_last(tx_last), .tx_ready(rdy_fs), .dp_out(dp_fs), .dm_out(dm_fs),
    .oe(oe_fs), .busy(busy_fs), .underrun(und_fs));

  usb_line_tx #(.CLKS_PER_BIT(CPB), .LOW_SPEED(1'b1), .SYNC_BITS(SYNC_N), .EOP_SE0_BITS(EOP_N)) dut_ls (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_last(tx_last), .tx_ready(rdy_ls), .dp_out(dp_ls), .dm_out(dm_ls),
    .oe(oe_ls), .busy(busy_ls), .underrun(und_ls));

  function automatic obs_t sample();
    return {dp_fs, dm_fs, oe_fs, busy_fs, rdy_fs, und_fs,
            dp_ls, dm_ls, oe_ls, busy_ls, rdy_ls, und_ls};
  endfunction

  // FS line code in, LS is the same code with dp/dm swapped.
  function automatic obs_t mk(logic [1:0] l, bit o, bit b, bit r, bit u);
    return {l, o, b, r, u, l[0], l[1], o, b, r, u};
  endfunction

  // Frame model: raw bit list -> stuffing -> NRZI -> per-clock expansion.
  task automatic build_expect(input bit with_last);
    bit         src[$];
    bit         sbnd[$];
    bit         raw[$];
    bit         rbnd[$];
    logic [1:0] lines[$];
    bit         lbnd[$];
    int         ones;
    int         und_idx;
    bit         lvl;
    exp_q.delete();
    for (int i = 0; i < SYNC_N; i++) begin
      src.push_back(i == SYNC_N - 1);
      sbnd.push_back(1'b0);
    end
    for (int j = 0; j < pkt.size(); j++) begin
      for (int b = 0; b < 8; b++) begin
        src.push_back(pkt[j][b]);
        sbnd.push_back(b == 7 && !(with_last && j == pkt.size() - 1));
      end
    end
    ones    = 0;
    und_idx = -1;
    for (int i = 0; i < src.size(); i++) begin
      raw.push_back(src[i]);
      rbnd.push_back(sbnd[i]);
      ones = src[i] ? ones + 1 : 0;
      if (i == src.size() - 1 && !with_last) und_idx = raw.size();
      if (ones == 6) begin
        raw.push_back(1'b0);
        rbnd.push_back(1'b0);
        ones = 0;
      end
    end
    lvl = 1'b1;
    for (int i = 0; i < raw.size(); i++) begin
      if (!raw[i]) lvl = !lvl;
      lines.push_back(lvl ? J : K);
      lbnd.push_back(rbnd[i]);
    end
    for (int i = 0; i < EOP_N; i++) begin
      lines.push_back(SE0);
      lbnd.push_back(1'b0);
    end
    lines.push_back(J);
    lbnd.push_back(1'b0);
    exp_q.push_back(mk(J, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int e = 0; e < lines.size(); e++)
      for (int c = 0; c < CPB; c++)
        exp_q.push_back(mk(lines[e], 1'b1, 1'b1, lbnd[e] && c == CPB - 1, e == und_idx && c == 0));
  endtask

  // Sends pkt as one packet starting now (just after a posedge) and checks
  // every clock from the handshake cycle until busy drops.
  task automatic run_packet(input bit with_last, input bit drop_ena, input string name,
                            output int busy_n, output int rdy_n, output int und_n, output int wait_n);
    int   k = 0;
    int   idx = 0;
    int   cyc = 0;
    int   shown = 0;
    bit   started = 1'b0;
    bit   done = 1'b0;
    bit   hs;
    obs_t o;
    busy_n = 0; rdy_n = 0; und_n = 0; wait_n = 0;
    build_expect(with_last);
    tx_valid = 1'b1;
    tx_data  = pkt[0];
    tx_last  = with_last && pkt.size() == 1;
    while (!done) begin
      @(negedge clk);
      o  = sample();
      hs = tx_valid && rdy_fs;
      if (hs) started = 1'b1;
      if (started) begin
        n_cmp++;
        if (k >= exp_q.size() || o !== exp_q[k]) begin
          n_err++;
          if (shown < 6)
            $display("FAIL %s cycle %0d: got %b want %b", name, k,
                     o, (k < exp_q.size()) ? exp_q[k] : 12'hxxx);
          shown++;
        end
        if (busy_fs) busy_n++;
        if (rdy_fs) rdy_n++;
        if (und_fs) und_n++;
        k++;
      end else begin
        wait_n++;
      end
      @(posedge clk);
      #1;
      if (hs) begin
        idx++;
        if (idx < pkt.size()) begin
          tx_data = pkt[idx];
          tx_last = with_last && idx == pkt.size() - 1;
        end else begin
          tx_valid = 1'b0;
          tx_data  = 8'($urandom);
          tx_last  = 1'($urandom);
        end
        if (drop_ena) ena = 1'b0;
      end
      cyc++;
      if (started && k > 1 && !busy_fs) done = 1'b1;
      if (cyc > 3000) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s timeout: got busy=%b want packet end within 3000 clks", name, busy_fs);
        done = 1'b1;
      end
    end
    ena = 1'b1;
    n_cmp++;
    if (k !== exp_q.size()) begin
      n_err++;
      $display("FAIL %s frame_len: got %0d want %0d clks", name, k, exp_q.size());
    end
    n_cmp++;
    if ({dp_fs, dm_fs, oe_fs, busy_fs, dp_ls, dm_ls, oe_ls, busy_ls} !== {J, 2'b00, 2'b01, 2'b00}) begin
      n_err++;
      $display("FAIL %s idle_after: got %b want %b", name,
               {dp_fs, dm_fs, oe_fs, busy_fs, dp_ls, dm_ls, oe_ls, busy_ls}, {J, 2'b00, 2'b01, 2'b00});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; tx_valid = 1'b1; tx_data = 8'h5A; tx_last = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({dp_fs, dm_fs, oe_fs, busy_fs, rdy_fs, und_fs} !== 6'b10_0000) begin
      n_err++;
      $display("FAIL reset_fs: got %b want %b", {dp_fs, dm_fs, oe_fs, busy_fs, rdy_fs, und_fs}, 6'b10_0000);
    end
    n_cmp++;
    if ({dp_ls, dm_ls, oe_ls, busy_ls, rdy_ls, und_ls} !== 6'b01_0000) begin
      n_err++;
      $display("FAIL reset_ls: got %b want %b", {dp_ls, dm_ls, oe_ls, busy_ls, rdy_ls, und_ls}, 6'b01_0000);
    end
    tx_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({rdy_fs, rdy_ls, busy_fs} !== 3'b110) begin
      n_err++;
      $display("FAIL idle_ready: got %b want %b", {rdy_fs, rdy_ls, busy_fs}, 3'b110);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_zero();
    int bn, rn, un, wn;
    pkt = '{8'h00};
    run_packet(1'b1, 1'b0, "byte00", bn, rn, un, wn);
    n_cmp++;
    if (bn !== 76) begin
      n_err++;
      $display("FAIL byte00_busy: got %0d want 76", bn);
    end
  endtask

  task automatic test_stuffing();
    int bn, rn, un, wn;
    pkt = '{8'hFF};
    run_packet(1'b1, 1'b0, "byteFF", bn, rn, un, wn);
    n_cmp++;
    if (bn !== (8 + 8 + 1 + 3) * CPB) begin
      n_err++;
      $display("FAIL byteFF_busy: got %0d want %0d", bn, (8 + 8 + 1 + 3) * CPB);
    end
    // last six data bits are ones: stuffed zero lands between bit 7 and EOP
    pkt = '{8'hFC};
    run_packet(1'b1, 1'b0, "byteFC", bn, rn, un, wn);
    n_cmp++;
    if (bn !== (8 + 8 + 1 + 3) * CPB) begin
      n_err++;
      $display("FAIL byteFC_busy: got %0d want %0d", bn, (8 + 8 + 1 + 3) * CPB);
    end
  endtask

  task automatic test_two_bytes();
    int bn, rn, un, wn;
    pkt = '{8'hA5, 8'h3C};
    run_packet(1'b1, 1'b0, "two_bytes", bn, rn, un, wn);
    n_cmp++;
    if (rn !== 2) begin
      n_err++;
      $display("FAIL two_bytes_ready: got %0d pulses want 2", rn);
    end
    n_cmp++;
    if (bn !== (8 + 16 + 3) * CPB) begin
      n_err++;
      $display("FAIL two_bytes_busy: got %0d want %0d", bn, (8 + 16 + 3) * CPB);
    end
  endtask

  task automatic test_underrun();
    int bn, rn, un, wn;
    pkt = '{8'h12};
    run_packet(1'b0, 1'b0, "underrun", bn, rn, un, wn);
    n_cmp++;
    if (un !== 1) begin
      n_err++;
      $display("FAIL underrun_pulse: got %0d clks want 1", un);
    end
    n_cmp++;
    if (bn !== (8 + 8 + 3) * CPB) begin
      n_err++;
      $display("FAIL underrun_busy: got %0d want %0d", bn, (8 + 8 + 3) * CPB);
    end
  endtask

  task automatic test_back_to_back();
    int bn, rn, un, wn;
    for (int p = 0; p < 3; p++) begin
      pkt = '{8'(8'h31 + p), 8'(8'hC7 ^ p)};
      run_packet(1'b1, p == 1, "b2b", bn, rn, un, wn);
      if (p > 0) begin
        n_cmp++;
        if (wn !== 0) begin
          n_err++;
          $display("FAIL b2b_gap: got %0d idle clks want 0", wn);
        end
      end
    end
  endtask

  task automatic test_reset_mid(input int hold_clks, input string name);
    int bn, rn, un, wn;
    int guard = 0;
    tx_valid = 1'b1; tx_data = 8'($urandom); tx_last = 1'b1;
    while (!rdy_fs && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (hold_clks) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dp_fs, dm_fs, oe_fs, busy_fs, rdy_fs, und_fs, dp_ls, dm_ls, oe_ls, busy_ls} !== 10'b10_0000_01_00) begin
      n_err++;
      $display("FAIL %s async: got %b want %b", name,
               {dp_fs, dm_fs, oe_fs, busy_fs, rdy_fs, und_fs, dp_ls, dm_ls, oe_ls, busy_ls}, 10'b10_0000_01_00);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({dp_fs, dm_fs, oe_fs, busy_fs} !== 4'b1000) begin
        n_err++;
        $display("FAIL %s no_eop: got %b want %b", name, {dp_fs, dm_fs, oe_fs, busy_fs}, 4'b1000);
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pkt = '{8'($urandom), 8'hFF};
    run_packet(1'b1, 1'b0, name, bn, rn, un, wn);
  endtask

  task automatic test_random();
    int bn, rn, un, wn;
    int len;
    bit wl;
    for (int p = 0; p < 25; p++) begin
      pkt.delete();
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 5))
          0:       pkt.push_back(8'hFF);
          1:       pkt.push_back(8'hFC);
          2:       pkt.push_back(8'h7F);
          default: pkt.push_back(8'($urandom));
        endcase
      end
      wl = $urandom_range(0, 99) < 85;
      run_packet(wl, $urandom_range(0, 3) == 0, "random", bn, rn, un, wn);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0;
    test_reset();
    test_single_zero();
    test_stuffing();
    test_two_bytes();
    test_underrun();
    test_back_to_back();
    test_reset_mid(10, "rst_in_sync");
    test_reset_mid(45, "rst_in_data");
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
